// File: rtl/i2s_clkgen_tdm.sv
// i2s_clkgen_tdm
//   I2S / left-justified / TDM (DSP-A) bit- and frame-clock generator.
//   Everything runs on mclk_in. BCK and LRCK are registered levels, so no
//   logic ever runs on a derived clock. Configuration is double-buffered:
//   cfg_load fills a shadow register, and the shadow becomes active at the
//   next frame wrap, or on the following cycle while the generator is idle.
//
// Ports
//   mclk_in      master clock (only clock)
//   rst          asynchronous active-high reset
//   en           run enable; low holds counters/outputs in reset state
//   cfg_half     BCK half-period in mclk cycles minus 1
//   cfg_bits     bits per slot minus 1
//   cfg_slots    slots per frame minus 1 (TDM only)
//   cfg_mode     0=I2S, 1=LJ, 2=TDM, 3=I2S
//   cfg_load     strobe capturing cfg_* into the shadow register
//   bck_oe, lrck_oe, mclk_oe  pad output enables
//   mclk         mclk_in gated by mclk_oe
//   bck, lrck    bit clock / frame clock pads (Hi-Z when disabled)
//   bit_strobe   one-cycle pulse on every BCK falling transition
//   frame_start  one-cycle pulse on the wrap to slot 0, bit 0
//   slot_idx, bit_idx  current position in the frame
//   cfg_pending  shadow configuration waiting to be applied
module i2s_clkgen_tdm #(
    parameter int DIV_W     = 4,
    parameter int BITS_W    = 5,
    parameter int SLOT_W    = 3,
    parameter int DEF_HALF  = 3,
    parameter int DEF_BITS  = 31,
    parameter int DEF_SLOTS = 1,
    parameter int DEF_MODE  = 0
) (
    input  logic              mclk_in,
    input  logic              rst,
    input  logic              en,
    input  logic [DIV_W-1:0]  cfg_half,
    input  logic [BITS_W-1:0] cfg_bits,
    input  logic [SLOT_W-1:0] cfg_slots,
    input  logic [1:0]        cfg_mode,
    input  logic              cfg_load,
    input  logic              bck_oe,
    input  logic              lrck_oe,
    input  logic              mclk_oe,
    output logic              mclk,
    output logic              bck,
    output logic              lrck,
    output logic              bit_strobe,
    output logic              frame_start,
    output logic [SLOT_W-1:0] slot_idx,
    output logic [BITS_W-1:0] bit_idx,
    output logic              cfg_pending
);

    localparam logic [DIV_W-1:0]  RST_HALF  = DIV_W'(DEF_HALF);
    localparam logic [BITS_W-1:0] RST_BITS  = BITS_W'(DEF_BITS);
    localparam logic [SLOT_W-1:0] RST_SLOTS = SLOT_W'(DEF_SLOTS);
    localparam logic [1:0]        RST_MODE  = 2'(DEF_MODE);
    // Last slot of the default frame: only TDM honours the slot count.
    localparam logic [SLOT_W-1:0] RST_SLOT_POS =
        (DEF_MODE == 2) ? SLOT_W'(DEF_SLOTS) : SLOT_W'(1);

    // Two-channel modes always run two slots regardless of cfg_slots.
    function automatic logic [SLOT_W-1:0] eff_slots(input logic [SLOT_W-1:0] s,
                                                    input logic [1:0]        m);
        eff_slots = (m == 2'd2) ? s : SLOT_W'(1);
    endfunction

    // Frame clock level for position (s,b) given last bit bl and last slot sl.
    function automatic logic lrck_at(input logic [SLOT_W-1:0] s,
                                     input logic [BITS_W-1:0] b,
                                     input logic [BITS_W-1:0] bl,
                                     input logic [SLOT_W-1:0] sl,
                                     input logic [1:0]        m);
        case (m)
            2'd1:    lrck_at = (s == '0);
            2'd2:    lrck_at = (s == sl) && (b == bl);
            default: lrck_at = ((s == '0) && (b == bl)) ||
                               ((s == SLOT_W'(1)) && (b != bl));
        endcase
    endfunction

    logic [DIV_W-1:0]  act_half,  sh_half,  nxt_half;
    logic [BITS_W-1:0] act_bits,  sh_bits,  nxt_bits;
    logic [SLOT_W-1:0] act_slots, sh_slots, nxt_slots;
    logic [1:0]        act_mode,  sh_mode,  nxt_mode;
    logic [DIV_W-1:0]  cnt;
    logic              bck_r;
    logic              lrck_r;

    logic [SLOT_W-1:0] cur_slots, nxt_slots_eff, adv_slot;
    logic [BITS_W-1:0] adv_bit;
    logic              fall, last_bit, last_slot, wrap, apply;

    assign cur_slots = eff_slots(act_slots, act_mode);
    assign fall      = en & bck_r & (cnt == '0);
    assign last_bit  = (bit_idx == act_bits);
    assign last_slot = (slot_idx == cur_slots);
    assign wrap      = fall & last_bit & last_slot;

    // A load on the apply cycle wins: the new shadow waits one more frame.
    assign apply = cfg_pending & ~cfg_load & (~en | wrap);

    assign nxt_half      = apply ? sh_half  : act_half;
    assign nxt_bits      = apply ? sh_bits  : act_bits;
    assign nxt_slots     = apply ? sh_slots : act_slots;
    assign nxt_mode      = apply ? sh_mode  : act_mode;
    assign nxt_slots_eff = eff_slots(nxt_slots, nxt_mode);

    assign adv_bit  = last_bit ? '0 : bit_idx + 1'b1;
    assign adv_slot = last_bit ? (last_slot ? '0 : slot_idx + 1'b1) : slot_idx;

    always_ff @(posedge mclk_in or posedge rst) begin
        if (rst) begin
            act_half    <= RST_HALF;
            act_bits    <= RST_BITS;
            act_slots   <= RST_SLOTS;
            act_mode    <= RST_MODE;
            sh_half     <= RST_HALF;
            sh_bits     <= RST_BITS;
            sh_slots    <= RST_SLOTS;
            sh_mode     <= RST_MODE;
            cfg_pending <= 1'b0;
            cnt         <= '0;
            bck_r       <= 1'b0;
            lrck_r      <= 1'b0;
            bit_strobe  <= 1'b0;
            frame_start <= 1'b0;
            slot_idx    <= RST_SLOT_POS;
            bit_idx     <= RST_BITS;
        end else begin
            if (cfg_load) begin
                sh_half     <= cfg_half;
                sh_bits     <= cfg_bits;
                sh_slots    <= cfg_slots;
                sh_mode     <= cfg_mode;
                cfg_pending <= 1'b1;
            end else if (apply) begin
                cfg_pending <= 1'b0;
            end
            act_half  <= nxt_half;
            act_bits  <= nxt_bits;
            act_slots <= nxt_slots;
            act_mode  <= nxt_mode;

            if (!en) begin
                // Park on the last position of the (possibly new) frame so the
                // first BCK fall after enable wraps straight to (0,0).
                cnt         <= '0;
                bck_r       <= 1'b0;
                lrck_r      <= 1'b0;
                bit_strobe  <= 1'b0;
                frame_start <= 1'b0;
                slot_idx    <= nxt_slots_eff;
                bit_idx     <= nxt_bits;
            end else begin
                // Reload uses the half-period active before this edge.
                if (cnt == '0) begin
                    bck_r <= ~bck_r;
                    cnt   <= act_half;
                end else begin
                    cnt <= cnt - 1'b1;
                end
                bit_strobe  <= fall;
                frame_start <= wrap;
                if (fall) begin
                    slot_idx <= adv_slot;
                    bit_idx  <= adv_bit;
                    // At a wrap the new position belongs to the newly applied config.
                    lrck_r   <= lrck_at(adv_slot, adv_bit, nxt_bits, nxt_slots_eff, nxt_mode);
                end
            end
        end
    end

    assign mclk = mclk_in & mclk_oe;
    assign bck  = bck_oe  ? bck_r  : 1'bz;
    assign lrck = lrck_oe ? lrck_r : 1'bz;

endmodule

// File: doc/i2s_clkgen_tdm.md
# i2s_clkgen_tdm

Parametrised I2S/TDM bit- and frame-clock generator. It derives BCK and LRCK/FSYNC from `mclk_in` with arbitrary divisors, slot widths and slot counts. It supports I2S, left-justified and TDM (DSP-A) framing and applies configuration changes glitch-free at frame boundaries. All state is clocked by `mclk_in`, and no logic runs on derived clocks. It sits behind the I2C register block in place of the fixed-ratio generator and exports slot/bit strobes for downstream serialisers.

## Interface
Parameters:
- `DIV_W`, 4: width of the BCK half-period field.
- `BITS_W`, 5: width of the slot-bits field (up to 2^BITS_W bits per slot).
- `SLOT_W`, 3: width of the slot-count field (up to 2^SLOT_W slots).
- `DEF_HALF`, 3: reset value of the active half-period.
- `DEF_BITS`, 31: reset value of the active bits-per-slot minus 1.
- `DEF_SLOTS`, 1: reset value of the active slots minus 1.
- `DEF_MODE`, 0: reset value of the active mode.

Ports:
- `mclk_in`  in  1  master clock; the only clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `en`  in  1  run enable. When low, the counters are held at their reset state.
- `cfg_half`  in  DIV_W  BCK half-period in mclk cycles, minus 1.
- `cfg_bits`  in  BITS_W  bits per slot minus 1.
- `cfg_slots`  in  SLOT_W  slots per frame minus 1. Ignored in I2S/LJ modes.
- `cfg_mode`  in  2  0=I2S, 1=left-justified, 2=TDM, 3=reserved (treated as I2S).
- `cfg_load`  in  1  one-cycle strobe that captures the cfg_* inputs into the shadow register.
- `bck_oe`, `lrck_oe`, `mclk_oe`  in  1  output enables.
- `mclk`  out  1  `mclk_in & mclk_oe` (combinational).
- `bck`  out  1  bit clock; Hi-Z when `bck_oe`=0.
- `lrck`  out  1  LR clock / frame sync; Hi-Z when `lrck_oe`=0.
- `bit_strobe`  out  1  one-mclk pulse on every BCK falling transition.
- `frame_start`  out  1  one-mclk pulse when position wraps to slot 0, bit 0.
- `slot_idx`  out  SLOT_W  current slot.
- `bit_idx`  out  BITS_W  current bit within the slot.
- `cfg_pending`  out  1  a shadow configuration is waiting to be applied.

## Operation
- **Active config:** half H, bits-1 B, slots-1 S, mode M. S is forced to 1 when M≠2.
- **BCK divider:** down-counter `cnt`.
  - When `cnt`=0, the internal `bck_r` toggles and `cnt` reloads H. Otherwise `cnt` decrements.
  - BCK period is 2(H+1) mclk cycles. H=0 gives mclk/2.
- **Position advance:** on each `bck_r` 1→0 transition:
  - If `bit_idx`≠B, `bit_idx`+1.
  - Otherwise `bit_idx`=0 and `slot_idx`+1, wrapping after S to 0.
  - The wrap to (0,0) asserts `frame_start`.
- **LRCK:** registered in the same cycle from the new position (s,b):
  - I2S: `lrck` = (s=0 & b=B) | (s=1 & b≠B). Left channel is low, and LRCK changes one BCK before the slot boundary.
  - LJ: `lrck` = (s=0).
  - TDM: `lrck` = (s=S & b=B). This is a one-BCK pulse ending at frame start.
- **Configuration update:**
  - `cfg_load` copies the cfg_* inputs to the shadow register and sets `cfg_pending`.
  - At the next wrap to (0,0), shadow→active and `cfg_pending` clears.
  - If `en`=0, shadow→active on the cycle after the load.
  - A `cfg_load` arriving on the wrap cycle overwrites the shadow and stays pending for the following frame.
  - The active H takes effect at its next `cnt` reload.
- **Enable and reset:**
  - `en`=0 synchronously forces the reset state of all counters and outputs.
  - Reset mid-frame aborts immediately with no completion of the current frame.

## Timing
- **Reset values:**
  - `bck_r`=0, `lrck`=0, `cnt`=0.
  - `slot_idx`=S_def, `bit_idx`=B_def (the last position).
  - `bit_strobe`=0, `frame_start`=0, `cfg_pending`=0.
  - Active config = DEF_*. Shadow = DEF_*.
- **Start-up:**
  - The first rising mclk edge with `en`=1 sets `bck_r`=1.
  - The first 1→0 transition, H+1 cycles later, wraps to (0,0), pulses `frame_start` and updates `lrck`.
- **Falling-edge alignment:** `bck_r` fall, position update, `lrck` update, `bit_strobe` and `frame_start` all occur on the same mclk edge. `lrck` therefore never changes on a BCK rising edge.
- **Frame length:** frame = (S+1)(B+1) BCK periods. fs = mclk / (2(H+1)(S+1)(B+1)).
- **Output enables:** the OE inputs are combinational to the pads and do not disturb the counters.

## Test plan
- **Defaults:** reset, en=1, defaults (H=3, B=31, I2S) → BCK period 8 mclk; `frame_start` every 512 mclk; `lrck` rises on the BCK fall where slot 0 / bit 31 is entered and falls where slot 1 / bit 31 is entered.
- **LJ:** load H=0, B=15, M=1 while running → change only after the next `frame_start`; afterwards BCK=mclk/2, `lrck` high for exactly 16 BCKs starting at `frame_start`, frame=64 mclk.
- **TDM:** load S=7, B=31, H=1, M=2 → 256 BCK per frame; `lrck` high exactly one BCK (slot 7, bit 31); `slot_idx` runs 0..7.
- **Late load:** `cfg_load` asserted on the wrap cycle → previous shadow not applied at that wrap; new values applied at the following wrap; `cfg_pending` high across the frame.
- **Idle load and mid-frame reset:** `en`=0 then `cfg_load` → active on next cycle, `cfg_pending` low. Separately, async `rst` mid-frame → all outputs at reset values within the same cycle.
- **Output enables:** `bck_oe`/`lrck_oe`=0 → pads Z while `bit_strobe` continues; `mclk_oe`=0 → `mclk` low.
